apb_bcd_sub_seq: RTL and testbench

APB-slave controller that sequences a one-digit combinational BCD subtract slice (dp_* ports) across DIGITS digits, LSD first, one digit per PCLK.
Holds operand, result and status registers.
Stalls APB reads of RESULT until the computation finishes.
Raises a level interrupt on completion; sits between the APB bus and the shared BCD digit-slice datapath.

---
 rtl/apb_bcd_sub_seq.sv | 203 ++++++++++++++++++++
 tb/tb_apb_bcd_sub_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bcd_sub_seq.sv
// APB slave that sequences a shared one-digit BCD subtract slice across
// DIGITS digits, least significant digit first, one digit per PCLK.
// Holds the operand, result and status registers. A RESULT read issued while
// the sequence is running is stalled until the final difference is available.
//
// Handshake: a transfer completes on the rising edge that ends an access-phase
// cycle (PSEL & PENABLE) in which PREADY=1. PREADY is combinational. PRDATA is
// registered and holds the read value during that completing cycle. PSLVERR is
// only meaningful while PREADY=1.
module apb_bcd_sub_seq #(
    parameter int          DIGITS      = 3,
    parameter logic [7:0]  CTRL_ADDR   = 8'h00,
    parameter logic [7:0]  RESULT_ADDR = 8'h04,
    parameter logic [7:0]  OPA_ADDR    = 8'h08,
    parameter logic [7:0]  OPB_ADDR    = 8'h0C,
    parameter logic [7:0]  STATUS_ADDR = 8'h10
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [3:0]  dp_a,
    output logic [3:0]  dp_b,
    output logic        dp_bin,
    input  logic [3:0]  dp_diff,
    input  logic        dp_bout,
    output logic        irq
);

    localparam int W = 4 * DIGITS;

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opb_q;
    logic [W-1:0]   result_q, result_d;
    logic           rborrow_q, rborrow_d;
    logic [2:0]     idx_q, idx_d;
    logic           borrow_q, borrow_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           ien_q, irq_q, blocked_q;
    logic [31:0]    prdata_q, rd_mux;
    logic [3:0]     dig_a, dig_b;
    logic           dig_bad;

    logic access, busy, rd_result, wr_en;
    logic wr_ctrl, wr_opa, wr_opb, wr_illegal, start_go, clr_go;
    logic unused_pwdata;

    // Bus decode. blocked_q keeps an access that straddled a reset from
    // completing; it clears once the bus leaves the access phase.
    assign access    = PSEL & PENABLE;
    assign busy      = (state_q == CALC);
    assign rd_result = !PWRITE && (PADDR == RESULT_ADDR);
    assign PREADY    = access & ~blocked_q & ~(rd_result & busy);
    assign wr_en     = PREADY & PWRITE;

    assign wr_ctrl    = wr_en && (PADDR == CTRL_ADDR) && !(busy && PWDATA[0]);
    assign wr_opa     = wr_en && (PADDR == OPA_ADDR) && !busy;
    assign wr_opb     = wr_en && (PADDR == OPB_ADDR) && !busy;
    assign wr_illegal = wr_en && ((PADDR == RESULT_ADDR) || (PADDR == STATUS_ADDR) ||
                        (busy && ((PADDR == OPA_ADDR) || (PADDR == OPB_ADDR) ||
                                  ((PADDR == CTRL_ADDR) && PWDATA[0]))));
    assign start_go   = wr_ctrl & PWDATA[0];
    assign clr_go     = wr_ctrl & PWDATA[2];

    assign PSLVERR       = wr_illegal;
    assign PRDATA        = prdata_q;
    assign irq           = irq_q;
    assign unused_pwdata = &{1'b0, PWDATA[31:W]};

    // Select the current digit of each operand for the slice.
    always_comb begin
        dig_a = 4'd0;
        dig_b = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                dig_a = opa_q[4*i +: 4];
                dig_b = opb_q[4*i +: 4];
            end
        end
    end

    assign dig_bad = (dig_a > 4'd9) || (dig_b > 4'd9);
    assign dp_a    = busy ? dig_a : 4'd0;
    assign dp_b    = busy ? dig_b : 4'd0;
    assign dp_bin  = busy ? borrow_q : 1'b0;

    // Sequencer next state: start, per-digit capture, invalid-digit abort.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        result_d  = result_q;
        rborrow_d = rborrow_q;
        done_d    = done_q;
        err_d     = err_q;
        if (clr_go) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d   = CALC;
                    idx_d     = 3'd0;
                    borrow_d  = 1'b0;
                    result_d  = '0;
                    rborrow_d = 1'b0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                end
            end
            CALC: begin
                if (dig_bad) begin
                    state_d   = IDLE;
                    idx_d     = 3'd0;
                    borrow_d  = 1'b0;
                    result_d  = '0;
                    rborrow_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == 3'(i)) result_d[4*i +: 4] = dp_diff;
                    end
                    borrow_d = dp_bout;
                    idx_d    = 3'(idx_q + 3'd1);
                    if (idx_q == 3'(DIGITS - 1)) begin
                        state_d   = IDLE;
                        rborrow_d = dp_bout;
                        done_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read mux; RESULT uses the next value so a stalled read returns the final digit.
    always_comb begin
        rd_mux = 32'd0;
        case (PADDR)
            CTRL_ADDR:   rd_mux[1] = ien_q;
            RESULT_ADDR: begin
                rd_mux[W-1:0] = result_d;
                rd_mux[31]    = rborrow_d;
            end
            OPA_ADDR:    rd_mux[W-1:0] = opa_q;
            OPB_ADDR:    rd_mux[W-1:0] = opb_q;
            STATUS_ADDR: rd_mux[2:0] = {err_q, done_q, busy};
            default:     rd_mux = 32'd0;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            borrow_q  <= 1'b0;
            result_q  <= '0;
            rborrow_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            borrow_q  <= borrow_d;
            result_q  <= result_d;
            rborrow_q <= rborrow_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Software-visible registers, read data, interrupt and post-reset bus guard.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            opa_q     <= '0;
            opb_q     <= '0;
            ien_q     <= 1'b0;
            irq_q     <= 1'b0;
            prdata_q  <= 32'd0;
            blocked_q <= 1'b1;
        end else begin
            if (wr_opa)  opa_q <= PWDATA[W-1:0];
            if (wr_opb)  opb_q <= PWDATA[W-1:0];
            if (wr_ctrl) ien_q <= PWDATA[1];
            irq_q <= done_q & ien_q;
            if (PSEL && !PWRITE) prdata_q <= rd_mux;
            if (!access) blocked_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_bcd_sub_seq.sv
// Directed bench for apb_bcd_sub_seq (DIGITS=3) with a behavioural BCD slice.
module tb_apb_bcd_sub_seq;

    localparam logic [7:0] CTRL   = 8'h00;
    localparam logic [7:0] RESULT = 8'h04;
    localparam logic [7:0] OPA    = 8'h08;
    localparam logic [7:0] OPB    = 8'h0C;
    localparam logic [7:0] STATUS = 8'h10;

    logic        PCLK = 1'b0;
    logic        PRESETn, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [3:0]  dp_a, dp_b, dp_diff;
    logic        dp_bin, dp_bout, irq;

    int checks = 0;
    int errors = 0;
    int slice_d;

    logic [31:0] rdata;
    logic        serr;
    int          waits;

    apb_bcd_sub_seq #(.DIGITS(3)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .dp_a(dp_a), .dp_b(dp_b),
        .dp_bin(dp_bin), .dp_diff(dp_diff), .dp_bout(dp_bout), .irq(irq)
    );

    // Clock
    always #5 PCLK = ~PCLK;

    // Behavioural one-digit BCD subtract slice.
    always_comb begin
        slice_d = int'(dp_a) - int'(dp_b) - int'(dp_bin);
        dp_bout = (slice_d < 0);
        dp_diff = (slice_d < 0) ? 4'(slice_d + 10) : 4'(slice_d);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_dp(input string tag, input logic [3:0] a, input logic [3:0] b, input logic bin);
        check(tag, 32'({dp_a, dp_b, dp_bin}), 32'({a, b, bin}));
    endtask

    // Called #1 after a rising edge; returns #1 after the completing edge.
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        int n;
        n = 0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        while (!PREADY && n < 40) begin
            n++;
            @(negedge PCLK);
        end
        check("wr_ready", 32'(PREADY), 32'd1);
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err, output int w);
        int n;
        n = 0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        while (!PREADY && n < 40) begin
            n++;
            @(negedge PCLK);
        end
        check("rd_ready", 32'(PREADY), 32'd1);
        d = PRDATA;
        err = PSLVERR;
        w = n;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr_ok(input logic [7:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
        check("wr_no_slverr", 32'(e), 32'd0);
    endtask

    task automatic rd_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        int          w;
        apb_read(a, d, e, w);
        check(tag, d, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h00; PWDATA = 32'd0;
        #12;
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pready", 32'(PREADY), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check_dp("rst_dp", 4'd0, 4'd0, 1'b0);
        @(negedge PCLK); PRESETn = 1'b1;
        @(posedge PCLK); #1;
        rd_expect("rst_status", STATUS, 32'h0);
        rd_expect("rst_result", RESULT, 32'h0);

        // 523 - 187 = 336, three BUSY cycles then DONE
        wr_ok(OPA, 32'h523);
        wr_ok(OPB, 32'h187);
        wr_ok(CTRL, 32'h1);
        check_dp("t1_dp0", 4'h3, 4'h7, 1'b0);
        @(posedge PCLK); #1;
        check_dp("t1_dp1", 4'h2, 4'h8, 1'b1);
        @(posedge PCLK); #1;
        check_dp("t1_dp2", 4'h5, 4'h1, 1'b1);
        @(posedge PCLK); #1;
        check_dp("t1_dp_idle", 4'h0, 4'h0, 1'b0);
        rd_expect("t1_result", RESULT, 32'h0000_0336);
        rd_expect("t1_status", STATUS, 32'h2);
        check("t1_irq_off", 32'(irq), 32'd0);

        // 187 - 523 = -336 -> 664 with borrow; interrupt timing and clear
        wr_ok(OPA, 32'h187);
        wr_ok(OPB, 32'h523);
        wr_ok(CTRL, 32'h3);
        check("t2_irq_busy", 32'(irq), 32'd0);
        repeat (3) begin @(posedge PCLK); #1; end
        check("t2_irq_at_done", 32'(irq), 32'd0);
        @(posedge PCLK); #1;
        check("t2_irq_rise", 32'(irq), 32'd1);
        rd_expect("t2_result", RESULT, 32'h8000_0664);
        wr_ok(CTRL, 32'h6);
        check("t2_irq_hold", 32'(irq), 32'd1);
        @(posedge PCLK); #1;
        check("t2_irq_clr", 32'(irq), 32'd0);
        rd_expect("t2_status", STATUS, 32'h0);

        // Invalid digit A in minuend: abort at index 1
        wr_ok(OPA, 32'h1A3);
        wr_ok(OPB, 32'h001);
        wr_ok(CTRL, 32'h1);
        check_dp("t3_dp0", 4'h3, 4'h1, 1'b0);
        @(posedge PCLK); #1;
        check_dp("t3_dp1", 4'hA, 4'h0, 1'b0);
        @(posedge PCLK); #1;
        check_dp("t3_dp_idle", 4'h0, 4'h0, 1'b0);
        rd_expect("t3_status", STATUS, 32'h6);
        rd_expect("t3_result", RESULT, 32'h0);
        check("t3_irq_off", 32'(irq), 32'd0);

        // RESULT read issued right after START stalls until done: 900 - 001 = 899
        wr_ok(OPA, 32'h900);
        wr_ok(OPB, 32'h001);
        wr_ok(CTRL, 32'h1);
        apb_read(RESULT, rdata, serr, waits);
        check("t4_result", rdata, 32'h0000_0899);
        check("t4_waits", 32'(waits), 32'd2);
        check("t4_slverr", 32'(serr), 32'd0);
        rd_expect("t4_status", STATUS, 32'h2);

        // Illegal writes
        wr_ok(OPA, 32'h523);
        wr_ok(OPB, 32'h187);
        wr_ok(CTRL, 32'h1);
        apb_write(OPA, 32'h999, serr);
        check("t5_busy_wr_slverr", 32'(serr), 32'd1);
        apb_read(RESULT, rdata, serr, waits);
        check("t5_result", rdata, 32'h0000_0336);
        check("t5_waits", 32'(waits), 32'd0);
        rd_expect("t5_opa", OPA, 32'h523);
        apb_write(STATUS, 32'hFFFF_FFFF, serr);
        check("t5_status_wr_slverr", 32'(serr), 32'd1);
        apb_write(RESULT, 32'h1234, serr);
        check("t5_result_wr_slverr", 32'(serr), 32'd1);
        rd_expect("t5_status", STATUS, 32'h2);
        apb_read(8'h20, rdata, serr, waits);
        check("t5_unmapped_rd", rdata, 32'h0);
        check("t5_unmapped_slverr", 32'(serr), 32'd0);
        apb_write(8'h24, 32'h5555, serr);
        check("t5_unmapped_wr_slverr", 32'(serr), 32'd0);
        wr_ok(OPB, 32'hF042);
        rd_expect("t5_opb_mask", OPB, 32'h042);

        // Reset on the 2nd CALC cycle with a stalled RESULT read outstanding
        wr_ok(OPB, 32'h187);
        wr_ok(CTRL, 32'h3);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = RESULT;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        check("t6_stall", 32'(PREADY), 32'd0);
        check_dp("t6_dp1", 4'h2, 4'h8, 1'b1);
        PRESETn = 1'b0;
        #1;
        check("t6_rst_pready", 32'(PREADY), 32'd0);
        check("t6_rst_prdata", PRDATA, 32'd0);
        check("t6_rst_pslverr", 32'(PSLVERR), 32'd0);
        check("t6_rst_irq", 32'(irq), 32'd0);
        check_dp("t6_rst_dp", 4'h0, 4'h0, 1'b0);
        @(negedge PCLK); PRESETn = 1'b1;
        @(posedge PCLK); #1;
        check("t6_read_terminated", 32'(PREADY), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        rd_expect("t6_status", STATUS, 32'h0);
        rd_expect("t6_result", RESULT, 32'h0);
        rd_expect("t6_opa", OPA, 32'h0);
        rd_expect("t6_ctrl", CTRL, 32'h0);
        wr_ok(OPA, 32'h523);
        wr_ok(OPB, 32'h187);
        wr_ok(CTRL, 32'h5);
        repeat (3) begin @(posedge PCLK); #1; end
        rd_expect("t6_result_after", RESULT, 32'h0000_0336);
        rd_expect("t6_status_after", STATUS, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
